random_matrix_filler: RTL and testbench

- Consumer stage for the xorshift32 multi-lane PRNG.
- On command, it generates a rows x cols matrix of bounded signed elements and writes it row-major into matrix storage through a valid/ready write port.
- It advances the generator with a one-cycle start pulse and buffers the lane words it receives.
- It maps each word into the range [val_min, val_max] and discards unused lanes at the end of the matrix.

---
 rtl/random_matrix_filler.sv | 154 +++++++++++++++
 tb/tb_random_matrix_filler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_matrix_filler.sv
`default_nettype none
// ============================================================================
// random_matrix_filler: fills a rows x cols matrix with bounded signed values
// drawn from a multi-lane xorshift32 PRNG, written row-major over valid/ready.
// Revision: 1.0
// ============================================================================
module random_matrix_filler #(
  parameter int NUM_LANES = 4,
  parameter int ELEM_W    = 16,
  parameter int MAX_DIM   = 32,
  parameter int DIM_W     = $clog2(MAX_DIM + 1),
  parameter int ADDR_W    = $clog2(MAX_DIM * MAX_DIM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DIM_W-1:0]        rows,
  input  logic [DIM_W-1:0]        cols,
  input  logic [ELEM_W-1:0]       val_min,
  input  logic [ELEM_W-1:0]       val_max,
  output logic                    rng_start,
  input  logic [NUM_LANES*32-1:0] rng_data,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [ELEM_W-1:0]       wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PROD_W = ELEM_W + 17;
  localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(NUM_LANES - 1);
  localparam logic [DIM_W-1:0]  c_max_dim   = DIM_W'(MAX_DIM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t              r_state;
  logic [31:0]         r_buf [NUM_LANES];
  logic [LANE_W-1:0]   r_lane;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_last;
  logic [ELEM_W-1:0]   r_min;
  logic [ELEM_W:0]     r_span;

  logic                w_cmd_bad;
  logic [2*DIM_W-1:0]  w_total;
  logic [ELEM_W:0]     w_span;
  logic [LANE_W-1:0]   w_next_lane;
  logic [31:0]         w_word;
  logic [15:0]         w_hi;
  logic [PROD_W-1:0]   w_prod;
  logic [ELEM_W:0]     w_scaled;
  logic [ELEM_W:0]     w_sum;

  assign w_cmd_bad = (rows == '0) || (cols == '0) ||
                     (rows > c_max_dim) || (cols > c_max_dim) ||
                     ($signed(val_min) > $signed(val_max));
  assign w_total   = {DIM_W'(0), rows} * {DIM_W'(0), cols};
  // min <= max on every accepted command, so span lands in 1 .. 2^ELEM_W.
  assign w_span    = {val_max[ELEM_W-1], val_max} - {val_min[ELEM_W-1], val_min}
                     + (ELEM_W + 1)'(1);

  // The element being loaded next: lane 0 straight off the generator while
  // fetching, otherwise the following buffered lane.
  assign w_next_lane = r_lane + LANE_W'(1);
  assign w_word      = (r_state == S_FETCH) ? rng_data[31:0] : r_buf[w_next_lane];
  assign w_hi        = 16'(w_word >> 16);
  assign w_prod      = {(ELEM_W + 1)'(0), w_hi} * {16'd0, r_span};
  assign w_scaled    = (ELEM_W + 1)'(w_prod >> 16);
  assign w_sum       = {r_min[ELEM_W-1], r_min} + w_scaled;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign wr_addr   = r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lane    <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      r_min     <= '0;
      r_span    <= '0;
      rng_start <= 1'b0;
      wr_valid  <= 1'b0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) r_buf[i] <= '0;
    end else begin
      rng_start <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_cmd_bad) begin
              err <= 1'b1;
            end else begin
              r_min     <= val_min;
              r_span    <= w_span;
              r_last    <= ADDR_W'(w_total - (2 * DIM_W)'(1));
              r_idx     <= '0;
              rng_start <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // rng_start is high this cycle, so rng_data still holds the
          // pre-advance words.
          for (int i = 0; i < NUM_LANES; i++) r_buf[i] <= rng_data[32*i +: 32];
          r_lane   <= '0;
          wr_valid <= 1'b1;
          wr_data  <= ELEM_W'(w_sum);
          r_state  <= S_EMIT;
        end
        S_EMIT: begin
          if (wr_ready) begin
            if (r_idx == r_last) begin
              wr_valid <= 1'b0;
              done     <= 1'b1;
              r_state  <= S_FIN;
            end else begin
              r_idx <= r_idx + ADDR_W'(1);
              if (r_lane == c_last_lane) begin
                wr_valid  <= 1'b0;
                rng_start <= 1'b1;
                r_state   <= S_FETCH;
              end else begin
                r_lane  <= w_next_lane;
                wr_data <= ELEM_W'(w_sum);
              end
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_random_matrix_filler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_random_matrix_filler: directed vector table plus reset, max-dimension runs.
// Revision: 1.0
// ============================================================================
module tb_random_matrix_filler;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [5:0]    rows = '0;
  logic [5:0]    cols = '0;
  logic [15:0]   val_min = '0;
  logic [15:0]   val_max = '0;
  logic          rng_start;
  logic [127:0]  rng_data;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [9:0]    wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;

  random_matrix_filler dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rows(rows), .cols(cols), .val_min(val_min), .val_max(val_max),
    .rng_start(rng_start), .rng_data(rng_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference xorshift32 generator; lane k is k+1 steps past the state.
  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic longint bmap(input logic [31:0] w, input longint lo, input longint hi);
    logic [15:0] h;
    h = w[31:16];
    return lo + ((longint'(h) * (hi - lo + 1)) >>> 16);
  endfunction

  bit           gen_mode = 1'b0;
  logic [127:0] fixed_lanes = '0;
  logic [31:0]  gen_state;
  logic [31:0]  g0, g1, g2, g3;
  assign g0 = xs(gen_state);
  assign g1 = xs(g0);
  assign g2 = xs(g1);
  assign g3 = xs(g2);
  assign rng_data = gen_mode ? {g3, g2, g1, g0} : fixed_lanes;

  always @(posedge clk or posedge rst) begin
    if (rst) gen_state <= 32'd1;
    else if (rng_start && gen_mode) gen_state <= g3;
  end

  // Monitor: records accepted writes and pulses, checks stall stability.
  logic [9:0]  q_addr [$];
  logic [15:0] q_data [$];
  int ncyc = 0, n_start = 0, n_done = 0, n_err = 0;
  int last_acc_cyc = 0, done_cyc = 0;
  bit prev_stall = 1'b0;
  logic [9:0]  held_addr;
  logic [15:0] held_data;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", longint'(wr_valid), 1);
        check("stall_addr", longint'(wr_addr), longint'(held_addr));
        check("stall_data", longint'(wr_data), longint'(held_data));
      end
      prev_stall = wr_valid && !wr_ready;
      held_addr  = wr_addr;
      held_data  = wr_data;
      if (wr_valid && wr_ready) begin
        q_addr.push_back(wr_addr);
        q_data.push_back(wr_data);
        last_acc_cyc = ncyc;
      end
      if (rng_start) n_start++;
      if (done) begin n_done++; done_cyc = ncyc; end
      if (err) n_err++;
    end
  end

  task automatic clear_mon();
    q_addr.delete();
    q_data.delete();
    n_start = 0;
    n_done  = 0;
    n_err   = 0;
  endtask

  // Issues one command and runs until done/err or the cycle budget expires.
  task automatic run_cmd(input int r, input int c, input int lo, input int hi,
                         input bit bp, input int budget);
    bit finished;
    clear_mon();
    rows      = 6'(r);
    cols      = 6'(c);
    val_min   = 16'(lo);
    val_max   = 16'(hi);
    cmd_valid = 1'b1;
    wr_ready  = !bp;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Bounds change after accept must not matter.
    rows    = 6'd9;
    cols    = 6'd9;
    val_min = 16'h8000;
    val_max = 16'h7FFF;
    finished = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (n_done > 0 || n_err > 0) begin finished = 1'b1; break; end
      wr_ready = bp ? ((i % 3) == 2) : 1'b1;
      @(posedge clk); #1;
    end
    check("terminated", longint'(finished), 1);
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int           r;
    int           c;
    int           lo;
    int           hi;
    logic [127:0] lanes;
    bit           bp;
    bit           bad;
    int           n;
    int           n_start;
  } vec_t;

  localparam logic [127:0] c_pat_a = {32'h40000000, 32'h00000000, 32'h80000000, 32'hFFFF0000};
  localparam logic [127:0] c_pat_b = {32'h12344444, 32'hFFFF3333, 32'h80002222, 32'h00001111};

  vec_t tab [9];
  int   exp_tab [9][8];

  initial begin
    tab[0] = '{2, 3, -5, 5, c_pat_a, 1'b0, 1'b0, 6, 2};
    tab[1] = '{2, 3, -5, 5, c_pat_a, 1'b1, 1'b0, 6, 2};
    tab[2] = '{0, 3, -5, 5, c_pat_a, 1'b0, 1'b1, 0, 0};
    tab[3] = '{2, 33, -5, 5, c_pat_a, 1'b0, 1'b1, 0, 0};
    tab[4] = '{2, 2, 3, 2, c_pat_a, 1'b0, 1'b1, 0, 0};
    tab[5] = '{2, 3, 7, 7, c_pat_a, 1'b0, 1'b0, 6, 2};
    tab[6] = '{1, 5, -32768, 32767, c_pat_b, 1'b0, 1'b0, 5, 2};
    tab[7] = '{4, 1, -5, 5, c_pat_a, 1'b0, 1'b0, 4, 1};
    tab[8] = '{33, 1, -5, 5, c_pat_a, 1'b0, 1'b1, 0, 0};
    exp_tab[0] = '{5, 0, -5, -3, 5, 0, 0, 0};
    exp_tab[1] = '{5, 0, -5, -3, 5, 0, 0, 0};
    exp_tab[2] = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_tab[3] = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_tab[4] = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_tab[5] = '{7, 7, 7, 7, 7, 7, 0, 0};
    exp_tab[6] = '{-32768, 0, 32767, -28108, -32768, 0, 0, 0};
    exp_tab[7] = '{5, 0, -5, -3, 0, 0, 0, 0};
    exp_tab[8] = '{0, 0, 0, 0, 0, 0, 0, 0};

    // Reset values, checked while rst is still held.
    #1;
    check("rst_cmd_ready", longint'(cmd_ready), 1);
    check("rst_busy", longint'(busy), 0);
    check("rst_wr_valid", longint'(wr_valid), 0);
    check("rst_rng_start", longint'(rng_start), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err", longint'(err), 0);
    check("rst_wr_addr", longint'(wr_addr), 0);
    check("rst_wr_data", longint'(wr_data), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a fill.
    fixed_lanes = c_pat_a;
    clear_mon();
    rows = 6'd2; cols = 6'd3; val_min = -16'sd5; val_max = 16'sd5;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wr_valid && q_addr.size() >= 1) break;
      @(posedge clk); #1;
    end
    check("midfill_in_emit", longint'(wr_valid), 1);
    rst = 1'b1;
    #1;
    check("midfill_wr_valid", longint'(wr_valid), 0);
    check("midfill_busy", longint'(busy), 0);
    check("midfill_cmd_ready", longint'(cmd_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midfill_no_done", longint'(n_done), 0);

    // Directed vector table.
    for (int v = 0; v < 9; v++) begin
      fixed_lanes = tab[v].lanes;
      run_cmd(tab[v].r, tab[v].c, tab[v].lo, tab[v].hi, tab[v].bp, 200);
      check($sformatf("v%0d_err", v), longint'(n_err), tab[v].bad ? 1 : 0);
      check($sformatf("v%0d_done", v), longint'(n_done), tab[v].bad ? 0 : 1);
      check($sformatf("v%0d_starts", v), longint'(n_start), longint'(tab[v].n_start));
      check($sformatf("v%0d_nwrites", v), longint'(q_addr.size()), longint'(tab[v].n));
      for (int k = 0; k < q_addr.size() && k < 8; k++) begin
        check($sformatf("v%0d_addr%0d", v, k), longint'(q_addr[k]), longint'(k));
        check($sformatf("v%0d_data%0d", v, k), longint'($signed(q_data[k])),
              longint'(exp_tab[v][k]));
      end
      if (!tab[v].bad)
        check($sformatf("v%0d_done_lat", v), longint'(done_cyc - last_acc_cyc), 1);
    end

    // Max-dimension fill against the reference generator.
    gen_mode = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("maxdim_lane0", longint'(rng_data[31:0]), longint'(32'h00042021));
    run_cmd(32, 32, -1000, 1000, 1'b0, 3000);
    check("maxdim_nwrites", longint'(q_addr.size()), 1024);
    check("maxdim_done", longint'(n_done), 1);
    check("maxdim_starts", longint'(n_start), 256);
    if (q_addr.size() == 1024) begin
      logic [31:0] s;
      int bad_addr, bad_data;
      s = 32'd1;
      bad_addr = 0;
      bad_data = 0;
      for (int k = 0; k < 1024; k++) begin
        s = xs(s);
        if (longint'(q_addr[k]) != longint'(k)) bad_addr++;
        if (longint'($signed(q_data[k])) != bmap(s, -1000, 1000)) bad_data++;
      end
      check("maxdim_first_data", longint'($signed(q_data[0])), -1000);
      check("maxdim_last_addr", longint'(q_addr[1023]), 1023);
      check("maxdim_addr_errors", longint'(bad_addr), 0);
      check("maxdim_data_errors", longint'(bad_data), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
